// File: rtl/instr_encoder.sv
// Packs an immediate plus register/funct fields into one RV32I instruction word per transfer.
// Optional build macro RANGE_CHECK_EN: drop requests whose immediate does not fit the format.
//
// state | meaning
// EMPTY | no word held, out_valid low
// FULL  | encoded word held on out_instr/out_addr, out_valid high
module instr_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_imm_src,
    input  logic [31:0]       in_imm,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        err_count,
    input  logic              clr_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          err_q, err_d;

    logic                accept;
    logic                xfer;
    logic                src_legal;
    logic                imm_legal;
    logic                push;
    logic                drop;
    logic [31:0]         enc_word;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        src_legal = 1'b0;
        case (in_imm_src)
            SRC_I, SRC_S, SRC_B, SRC_U, SRC_J: src_legal = 1'b1;
            default:                           src_legal = 1'b0;
        endcase
    end

`ifdef RANGE_CHECK_EN
    // A value fits N signed bits when every bit above N-1 copies bit N-1.
    always_comb begin
        imm_legal = 1'b0;
        case (in_imm_src)
            SRC_I, SRC_S: imm_legal = (in_imm[31:11] == {21{in_imm[11]}});
            SRC_B:        imm_legal = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
            SRC_J:        imm_legal = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
            SRC_U:        imm_legal = (in_imm[11:0] == 12'h000);
            default:      imm_legal = 1'b0;
        endcase
    end
`else
    assign imm_legal = 1'b1;
`endif

    assign push = accept && src_legal && imm_legal;
    assign drop = accept && !(src_legal && imm_legal);

    always_comb begin
        enc_word = 32'h0;
        case (in_imm_src)
            SRC_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            SRC_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            SRC_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            SRC_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
            SRC_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
            default: enc_word = 32'h0;
        endcase
    end

    // The address belongs to the held word, so it only moves when that word leaves.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;

        case (state_q)
            EMPTY: begin
                if (push) state_d = FULL;
            end
            FULL: begin
                if (push)      state_d = FULL;
                else if (xfer) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (push) instr_d = enc_word;
        if (xfer) addr_d  = addr_q + ADDR_W'(4);

        if (clr_err)                     err_d = 8'h00;
        else if (drop && err_q != 8'hFF) err_d = err_q + 8'h01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            instr_q <= 32'h0;
            addr_q  <= BASE_ADDR;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: formats, back-to-back, stall, drops and error counter.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_src;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [7:0]  err_count;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_count(err_count), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_imm_src = 3'b000;
        in_imm     = 32'h0;
        in_opcode  = 7'h0;
        in_rd      = 5'h0;
        in_funct3  = 3'h0;
        in_rs1     = 5'h0;
        in_rs2     = 5'h0;
    endtask

    task automatic set_req(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                           input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid   = 1'b1;
        in_imm_src = src;
        in_imm     = imm;
        in_opcode  = op;
        in_rd      = rd;
        in_funct3  = f3;
        in_rs1     = rs1;
        in_rs2     = rs2;
    endtask

    task automatic do_reset();
        idle();
        clr_err = 1'b0;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", out_addr); end
        checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    // Unused fields carry junk to confirm each format ignores them.
    task automatic test_formats();
        logic [2:0]  src [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] imm [5] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFF4, 32'h12345000, 32'h000A67F8};
        logic [6:0]  op  [5] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F};
        logic [4:0]  rd  [5] = '{5'd0, 5'h1F, 5'h1F, 5'd0, 5'd1};
        logic [2:0]  f3  [5] = '{3'd0, 3'd2, 3'd0, 3'd7, 3'd7};
        logic [4:0]  rs1 [5] = '{5'd0, 5'd9, 5'd4, 5'h1F, 5'h1F};
        logic [4:0]  rs2 [5] = '{5'h1F, 5'd6, 5'd4, 5'h1F, 5'h1F};
        logic [31:0] exp [5] = '{32'hFFF00013, 32'h0064A423, 32'hFE420AE3, 32'h12345037, 32'h7F8A60EF};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(src[i], imm[i], op[i], rd[i], f3[i], rs1[i], rs2[i]);
            step();
            idle();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %b exp 1", i, out_valid); end
            checks++; if (out_instr !== exp[i]) begin errors++; $display("FAIL fmt%0d_instr got %h exp %h", i, out_instr, exp[i]); end
            checks++; if (out_addr !== 32'(4 * i)) begin errors++; $display("FAIL fmt%0d_addr got %h exp %h", i, out_addr, 32'(4 * i)); end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_drain got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  src [3] = '{3'd0, 3'd3, 3'd0};
        logic [31:0] imm [3] = '{32'h1, 32'hABCDE000, 32'h7FF};
        logic [6:0]  op  [3] = '{7'h13, 7'h37, 7'h13};
        logic [4:0]  rd  [3] = '{5'd1, 5'd3, 5'd0};
        logic [4:0]  rs1 [3] = '{5'd2, 5'd0, 5'd0};
        logic [31:0] exp [3] = '{32'h00110093, 32'hABCDE1B7, 32'h7FF00013};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(src[i], imm[i], op[i], rd[i], 3'd0, rs1[i], 5'd0);
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b exp 1", i, out_valid); end
            checks++; if (out_instr !== exp[i]) begin errors++; $display("FAIL b2b%0d_instr got %h exp %h", i, out_instr, exp[i]); end
            checks++; if (out_addr !== 32'(4 * i)) begin errors++; $display("FAIL b2b%0d_addr got %h exp %h", i, out_addr, 32'(4 * i)); end
        end
        idle();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", out_valid); end
        checks++; if (out_addr !== 32'hC) begin errors++; $display("FAIL b2b_end_addr got %h exp 0000000c", out_addr); end
        // Reset while a word is held must discard it immediately.
        out_ready = 1'b0;
        set_req(3'd0, 32'h5, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0);
        step();
        idle();
        reset = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL midreset_instr got %h exp 00000000", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL midreset_addr got %h exp 00000000", out_addr); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        set_req(3'd0, 32'h5, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0);
        step();
        checks++; if (out_instr !== 32'h00500113) begin errors++; $display("FAIL stall_first got %h exp 00500113", out_instr); end
        set_req(3'd0, 32'hFFFFF800, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready got %b exp 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got %b exp 1", i, out_valid); end
            checks++; if (out_instr !== 32'h00500113) begin errors++; $display("FAIL stall%0d_instr got %h exp 00500113", i, out_instr); end
            checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL stall%0d_addr got %h exp 00000000", i, out_addr); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        step();
        idle();
        checks++; if (out_instr !== 32'h80000013) begin errors++; $display("FAIL release_instr got %h exp 80000013", out_instr); end
        checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL release_addr got %h exp 00000004", out_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %b exp 1", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain got %b exp 0", out_valid); end
        checks++; if (out_addr !== 32'h8) begin errors++; $display("FAIL release_end_addr got %h exp 00000008", out_addr); end
    endtask

    task automatic test_errors();
        logic [31:0] base;
        do_reset();
        out_ready = 1'b1;
        set_req(3'b101, 32'h0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0);
        step();
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid got %b exp 0", out_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL illegal_err got %0d exp 1", err_count); end
        set_req(3'd2, 32'h3, 7'h63, 5'd0, 3'd0, 5'd4, 5'd4);
        step();
        idle();
`ifdef RANGE_CHECK_EN
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL range_valid got %b exp 0", out_valid); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL range_err got %0d exp 2", err_count); end
        base = 32'h0;
`else
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL trunc_valid got %b exp 1", out_valid); end
        checks++; if (out_instr !== 32'h00420163) begin errors++; $display("FAIL trunc_instr got %h exp 00420163", out_instr); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL trunc_err got %0d exp 1", err_count); end
        base = 32'h4;
`endif
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_err got %0d exp 0", err_count); end
        // Drop while FULL: the held word still leaves in the same cycle.
        set_req(3'd0, 32'h5, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0);
        step();
        checks++; if (out_addr !== base) begin errors++; $display("FAIL full_drop_addr0 got %h exp %h", out_addr, base); end
        set_req(3'b110, 32'h0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0);
        step();
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drop_valid got %b exp 0", out_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL full_drop_err got %0d exp 1", err_count); end
        checks++; if (out_addr !== base + 32'h4) begin errors++; $display("FAIL full_drop_addr got %h exp %h", out_addr, base + 32'h4); end
        set_req(3'b111, 32'h0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0);
        clr_err = 1'b1;
        step();
        idle();
        clr_err = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", err_count); end
        set_req(3'b111, 32'h0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0);
        repeat (260) step();
        idle();
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL saturate got %0d exp 255", err_count); end
    endtask

    initial begin
        reset     = 1'b1;
        clr_err   = 1'b0;
        out_ready = 1'b1;
        idle();
        test_reset();
        test_formats();
        test_back_to_back();
        test_stall();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
